mem_bus_seq: RTL and testbench

Memory-bus sequencer between the CPU core's memory port and the 15-bit pin bus plus the write-strobe pin. Accepts one read or write request at a time over a valid/ready handshake. Drives a fixed-cycle address/data phase sequence on the pins and samples read data from the 8-bit input pins after a programmable wait. Returns a one-cycle response pulse.

---
 rtl/mem_bus_pkg.sv | 6 +
 rtl/mem_bus_seq.sv | 102 ++++++++++
 tb/tb_mem_bus_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared FSM states and default widths for the memory-bus sequencer
package mem_bus_pkg;
  localparam int MEM_ADDR_W = 15;
  localparam int MEM_DATA_W = 8;
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, DATA, DONE} state_t;
endpackage

// File: rtl/mem_bus_seq.sv
// mem_bus_seq: sequences single CPU read/write requests onto the pin bus with a fixed phase order
module mem_bus_seq
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] bus_out,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_in
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || DATA_W > ADDR_W) begin : g_bad_param
    $error("mem_bus_seq: WAIT_CYCLES must be 1..15 and DATA_W <= ADDR_W");
  end
  state_t            r_state, w_state_nxt;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_bus_out, w_bus_out_nxt;
  logic              r_bus_we, w_bus_we_nxt;
  logic              r_rsp, w_rsp_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              w_accept;
  // Outputs are registered, so the comb block computes the values for the next state's cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bus_out_nxt = r_bus_out;
    w_bus_we_nxt  = 1'b0;
    w_rsp_nxt     = 1'b0;
    w_rdata_nxt   = r_rdata;
    w_accept      = 1'b0;
    case (r_state)
      IDLE: if (req_valid) begin
        w_accept      = 1'b1;
        w_state_nxt   = ADDR;
        w_bus_out_nxt = req_addr;
        w_bus_we_nxt  = req_write;
      end
      ADDR: if (r_write) begin
        w_state_nxt   = DATA;
        w_bus_out_nxt = ADDR_W'(r_wdata);
        w_bus_we_nxt  = 1'b1;
      end else begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = CW'(WAIT_CYCLES);
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = DONE;
          w_rdata_nxt = bus_in;
          w_rsp_nxt   = 1'b1;
        end
      end
      DATA: begin
        w_state_nxt = DONE;
        w_rsp_nxt   = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_bus_out <= '0;
      r_bus_we  <= 1'b0;
      r_rsp     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bus_out <= w_bus_out_nxt;
      r_bus_we  <= w_bus_we_nxt;
      r_rsp     <= w_rsp_nxt;
      r_rdata   <= w_rdata_nxt;
      if (w_accept) begin
        r_write <= req_write;
        r_wdata <= req_wdata;
      end
    end
  end
  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp;
  assign rsp_rdata = r_rdata;
  assign bus_out   = r_bus_out;
  assign bus_we    = r_bus_we;
endmodule

// File: tb/tb_mem_bus_seq.sv
// tb_mem_bus_seq: directed checks of the sequencer with WAIT_CYCLES=2 and WAIT_CYCLES=1 builds
module tb_mem_bus_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, req_ready, rsp_valid, bus_we;
  logic [14:0] req_addr, bus_out;
  logic [7:0]  req_wdata, rsp_rdata, bus_in;
  logic        req_valid1, req_write1, req_ready1, rsp_valid1, bus_we1;
  logic [14:0] req_addr1, bus_out1;
  logic [7:0]  req_wdata1, rsp_rdata1, bus_in1;
  int n_asrt = 0;
  int n_fail = 0;
  int n_rsp;
  always #5 clk = ~clk;
  mem_bus_seq #(.ADDR_W(15), .DATA_W(8), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .bus_out(bus_out),
    .bus_we(bus_we), .bus_in(bus_in)
  );
  mem_bus_seq #(.ADDR_W(15), .DATA_W(8), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .bus_out(bus_out1),
    .bus_we(bus_we1), .bus_in(bus_in1)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h1234; req_wdata = 8'h00; bus_in = 8'h00;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = 15'h0; req_wdata1 = 8'h00; bus_in1 = 8'h00;
    step(); step();
    chk("rst bus_out", bus_out, 0);
    chk("rst bus_we", bus_we, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1; req_valid = 1'b0;
    step();
    chk("post-rst req_ready", req_ready, 1);
    chk("post-rst bus_out", bus_out, 0);
    // Read 0x1234, bus_in carries 0xA5 only in cycle 3
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h1234;
    step();
    req_valid = 1'b0;
    chk("rd c1 bus_out", bus_out, 15'h1234);
    chk("rd c1 bus_we", bus_we, 0);
    chk("rd c1 req_ready", req_ready, 0);
    step();
    chk("rd c2 bus_out", bus_out, 15'h1234);
    chk("rd c2 bus_we", bus_we, 0);
    chk("rd c2 rsp_valid", rsp_valid, 0);
    step();
    bus_in = 8'hA5;
    chk("rd c3 bus_out", bus_out, 15'h1234);
    chk("rd c3 bus_we", bus_we, 0);
    chk("rd c3 rsp_valid", rsp_valid, 0);
    step();
    bus_in = 8'h00;
    chk("rd c4 rsp_valid", rsp_valid, 1);
    chk("rd c4 rsp_rdata", rsp_rdata, 8'hA5);
    chk("rd c4 bus_we", bus_we, 0);
    step();
    chk("rd c5 rsp_valid", rsp_valid, 0);
    chk("rd c5 rdata held", rsp_rdata, 8'hA5);
    chk("rd c5 req_ready", req_ready, 1);
    // Write 0x3C to 0x7FFF
    req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h7FFF; req_wdata = 8'h3C;
    step();
    req_valid = 1'b0;
    chk("wr c1 bus_out", bus_out, 15'h7FFF);
    chk("wr c1 bus_we", bus_we, 1);
    step();
    chk("wr c2 bus_out", bus_out, 15'h003C);
    chk("wr c2 bus_we", bus_we, 1);
    chk("wr c2 rsp_valid", rsp_valid, 0);
    step();
    chk("wr c3 rsp_valid", rsp_valid, 1);
    chk("wr c3 bus_we", bus_we, 0);
    chk("wr c3 rdata kept", rsp_rdata, 8'hA5);
    chk("wr c3 bus_out", bus_out, 15'h003C);
    step();
    chk("wr c4 rsp_valid", rsp_valid, 0);
    // Back-to-back: write then read with req_valid held high
    req_valid = 1'b1; req_write = 1'b1; req_addr = 15'h0100; req_wdata = 8'h11; bus_in = 8'h77;
    step();
    n_rsp = 0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 1) begin
        chk("b2b c1 bus_out", bus_out, 15'h0100);
        req_write = 1'b0; req_addr = 15'h0200;
      end
      if (c == 3) chk("b2b c3 rsp_valid", rsp_valid, 1);
      if (c == 4) begin
        chk("b2b c4 req_ready", req_ready, 1);
        chk("b2b c4 bus_out", bus_out, 15'h0011);
      end
      if (c == 5) begin
        chk("b2b c5 bus_out", bus_out, 15'h0200);
        chk("b2b c5 bus_we", bus_we, 0);
        chk("b2b c5 req_ready", req_ready, 0);
        req_valid = 1'b0;
      end
      if (c == 8) begin
        chk("b2b c8 rsp_valid", rsp_valid, 1);
        chk("b2b c8 rsp_rdata", rsp_rdata, 8'h77);
      end
      n_rsp += int'(rsp_valid);
      step();
    end
    chk("b2b pulse count", n_rsp, 2);
    // Reset during WAIT of a read
    req_valid = 1'b1; req_write = 1'b0; req_addr = 15'h0ABC; bus_in = 8'h99;
    step();
    req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst bus_out", bus_out, 0);
    chk("mrst bus_we", bus_we, 0);
    chk("mrst rsp_valid", rsp_valid, 0);
    chk("mrst rsp_rdata", rsp_rdata, 0);
    chk("mrst req_ready", req_ready, 1);
    n_rsp = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_rsp += int'(rsp_valid);
    end
    chk("mrst no pulse", n_rsp, 0);
    req_valid = 1'b1; req_addr = 15'h0042; bus_in = 8'h5C;
    step();
    req_valid = 1'b0;
    chk("mrst rd c1 bus_out", bus_out, 15'h0042);
    step(); step(); step();
    chk("mrst rd c4 rsp_valid", rsp_valid, 1);
    chk("mrst rd c4 rsp_rdata", rsp_rdata, 8'h5C);
    // WAIT_CYCLES=1 build
    req_valid1 = 1'b1; req_write1 = 1'b0; req_addr1 = 15'h0001; bus_in1 = 8'h5A;
    step();
    req_valid1 = 1'b0;
    chk("w1 c1 bus_out", bus_out1, 15'h0001);
    chk("w1 c1 bus_we", bus_we1, 0);
    step();
    chk("w1 c2 rsp_valid", rsp_valid1, 0);
    step();
    chk("w1 c3 rsp_valid", rsp_valid1, 1);
    chk("w1 c3 rsp_rdata", rsp_rdata1, 8'h5A);
    step();
    chk("w1 c4 rsp_valid", rsp_valid1, 0);
    chk("w1 c4 req_ready", req_ready1, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
